// File: rtl/stopwatch.sv
// Count-up hr:min:sec stopwatch with button edge detection, lap capture and an hour limit.
// Define STOPWATCH_WRAP_EN to wrap to 00:00:00 at MAX_HR:59:59 instead of entering OVF.
module stopwatch #(
    parameter int MAX_HR = 23
) (
    input  logic       clk_1hz,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       lap,
    input  logic       clear,
    output logic [4:0] hr,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [4:0] lap_hr,
    output logic [5:0] lap_min,
    output logic [5:0] lap_sec,
    output logic       lap_valid,
    output logic [3:0] lap_cnt,
    output logic       running,
    output logic       overflow
);

    localparam logic [4:0] HR_TOP = 5'(MAX_HR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVF   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic start_d, stop_d, lap_d, clear_d;
    logic start_e, stop_e, lap_e, clear_e;
    logic at_max;
    logic inc_en, cap_en;
    logic [4:0] hr_nxt;
    logic [5:0] min_nxt, sec_nxt;

    function automatic logic [3:0] lap_cnt_sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Delay registers come out of reset high so a button held through reset is not seen as a press
    always_ff @(posedge clk_1hz) begin
        if (!rst_n) begin
            start_d <= 1'b1;
            stop_d  <= 1'b1;
            lap_d   <= 1'b1;
            clear_d <= 1'b1;
        end else begin
            start_d <= start;
            stop_d  <= stop;
            lap_d   <= lap;
            clear_d <= clear;
        end
    end

    assign start_e = start & ~start_d;
    assign stop_e  = stop  & ~stop_d;
    assign lap_e   = lap   & ~lap_d;
    assign clear_e = clear & ~clear_d;

    assign at_max = (hr == HR_TOP) && (min == 6'd59) && (sec == 6'd59);
    assign inc_en = (state == S_RUN) && !stop_e && !clear_e;
    assign cap_en = (state == S_RUN) && lap_e && !clear_e;

    always_ff @(posedge clk_1hz) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear_e) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_e) state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (stop_e) begin
                        state_nxt = S_PAUSE;
                    end
`ifndef STOPWATCH_WRAP_EN
                    else if (at_max) begin
                        state_nxt = S_OVF;
                    end
`endif
                end
                S_PAUSE: begin
                    if (start_e) state_nxt = S_RUN;
                end
                S_OVF: begin
                    state_nxt = S_OVF;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef STOPWATCH_WRAP_EN
    logic ovf_pulse;

    always_ff @(posedge clk_1hz) begin
        if (!rst_n || clear_e) begin
            ovf_pulse <= 1'b0;
        end else begin
            ovf_pulse <= inc_en && at_max;
        end
    end

    always_comb begin
        running  = (state == S_RUN);
        overflow = ovf_pulse;
    end
`else
    always_comb begin
        running  = (state == S_RUN);
        overflow = (state == S_OVF);
    end
`endif

    // Ripple carry sec -> min -> hr; at the hour limit either wrap or hold
    always_comb begin
        hr_nxt  = hr;
        min_nxt = min;
        sec_nxt = sec;
        if (sec != 6'd59) begin
            sec_nxt = sec + 6'd1;
        end else if (min != 6'd59) begin
            sec_nxt = '0;
            min_nxt = min + 6'd1;
        end else if (hr != HR_TOP) begin
            sec_nxt = '0;
            min_nxt = '0;
            hr_nxt  = hr + 5'd1;
        end else begin
`ifdef STOPWATCH_WRAP_EN
            sec_nxt = '0;
            min_nxt = '0;
            hr_nxt  = '0;
`endif
        end
    end

    always_ff @(posedge clk_1hz) begin
        if (!rst_n || clear_e) begin
            hr  <= '0;
            min <= '0;
            sec <= '0;
        end else if (inc_en) begin
            hr  <= hr_nxt;
            min <= min_nxt;
            sec <= sec_nxt;
        end
    end

    // Lap captures the count as it stood before this edge's increment
    always_ff @(posedge clk_1hz) begin
        if (!rst_n || clear_e) begin
            lap_hr    <= '0;
            lap_min   <= '0;
            lap_sec   <= '0;
            lap_valid <= 1'b0;
            lap_cnt   <= '0;
        end else if (cap_en) begin
            lap_hr    <= hr;
            lap_min   <= min;
            lap_sec   <= sec;
            lap_valid <= 1'b1;
            lap_cnt   <= lap_cnt_sat_inc(lap_cnt);
        end
    end

endmodule

// File: tb/tb_stopwatch.sv
// Self-checking bench for stopwatch (MAX_HR=1): vector table, hand-written corner sequences
// and randomized buttons checked against a total-seconds reference model.
`timescale 1ns/1ps
module tb_stopwatch;

    localparam int MAX_HR = 1;
    localparam int LIMIT  = MAX_HR * 3600 + 59 * 60 + 59;

    logic       clk_1hz = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, lap = 1'b0, clear = 1'b0;
    logic [4:0] hr, lap_hr;
    logic [5:0] min, sec, lap_min, lap_sec;
    logic       lap_valid, running, overflow;
    logic [3:0] lap_cnt;

    int checks = 0;
    int failures = 0;

    stopwatch #(.MAX_HR(MAX_HR)) dut (
        .clk_1hz(clk_1hz), .rst_n(rst_n), .start(start), .stop(stop), .lap(lap), .clear(clear),
        .hr(hr), .min(min), .sec(sec), .lap_hr(lap_hr), .lap_min(lap_min), .lap_sec(lap_sec),
        .lap_valid(lap_valid), .lap_cnt(lap_cnt), .running(running), .overflow(overflow)
    );

    always #5 clk_1hz = ~clk_1hz;

    // Reference model: elapsed time as a plain number of seconds, mode 0=idle 1=run 2=pause 3=ovf
    int m_t = 0, m_lap_t = 0, m_lap_cnt = 0, m_mode = 0;
    bit m_lap_valid = 0, m_pulse = 0;
    bit p_s = 1, p_p = 1, p_l = 1, p_c = 1;

    function automatic void model_step(bit rn, bit s, bit p, bit l, bit c);
        bit es, ep, el, ec;
        m_pulse = 0;
        if (!rn) begin
            m_t = 0; m_lap_t = 0; m_lap_cnt = 0; m_mode = 0; m_lap_valid = 0;
            p_s = 1; p_p = 1; p_l = 1; p_c = 1;
            return;
        end
        es = s && !p_s; ep = p && !p_p; el = l && !p_l; ec = c && !p_c;
        p_s = s; p_p = p; p_l = l; p_c = c;
        if (ec) begin
            m_mode = 0; m_t = 0; m_lap_t = 0; m_lap_cnt = 0; m_lap_valid = 0;
        end else if (m_mode == 0 || m_mode == 2) begin
            if (es) m_mode = 1;
        end else if (m_mode == 1) begin
            if (el) begin
                m_lap_t = m_t;
                m_lap_valid = 1;
                if (m_lap_cnt < 15) m_lap_cnt++;
            end
            if (ep) m_mode = 2;
            else if (m_t == LIMIT) begin
`ifdef STOPWATCH_WRAP_EN
                m_t = 0;
                m_pulse = 1;
`else
                m_mode = 3;
`endif
            end else m_t++;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input bit rn, input bit s, input bit p, input bit l, input bit c);
        @(negedge clk_1hz);
        rst_n = rn; start = s; stop = p; lap = l; clear = c;
        @(posedge clk_1hz);
        model_step(rn, s, p, l, c);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        bit exp_ovf;
`ifdef STOPWATCH_WRAP_EN
        exp_ovf = m_pulse;
`else
        exp_ovf = (m_mode == 3);
`endif
        chk({tag, ".hr"}, 32'(hr), m_t / 3600);
        chk({tag, ".min"}, 32'(min), (m_t / 60) % 60);
        chk({tag, ".sec"}, 32'(sec), m_t % 60);
        chk({tag, ".lap_hr"}, 32'(lap_hr), m_lap_t / 3600);
        chk({tag, ".lap_min"}, 32'(lap_min), (m_lap_t / 60) % 60);
        chk({tag, ".lap_sec"}, 32'(lap_sec), m_lap_t % 60);
        chk({tag, ".lap_valid"}, 32'(lap_valid), 32'(m_lap_valid));
        chk({tag, ".lap_cnt"}, 32'(lap_cnt), m_lap_cnt);
        chk({tag, ".running"}, 32'(running), 32'(m_mode == 1));
        chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic do_reset();
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit rn, s, p, l, c;
        int eh, em, es, erun, elv, elc, elsec;
    } vec_t;

    vec_t vecs[20];

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[4]  = '{1, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0};
        vecs[5]  = '{1, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0};
        vecs[6]  = '{1, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0};
        vecs[7]  = '{1, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0};
        vecs[8]  = '{1, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0};
        vecs[10] = '{1, 0, 0, 1, 0, 0, 0, 4, 1, 1, 1, 3};
        vecs[11] = '{1, 0, 0, 1, 0, 0, 0, 5, 1, 1, 1, 3};
        vecs[12] = '{1, 0, 0, 0, 0, 0, 0, 6, 1, 1, 1, 3};
        vecs[13] = '{1, 0, 1, 1, 0, 0, 0, 6, 0, 1, 2, 6};
        vecs[14] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[15] = '{1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
        vecs[16] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[17] = '{1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0};
        vecs[18] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[19] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Vector table
        for (int i = 0; i < 20; i++) begin
            tick(vecs[i].rn, vecs[i].s, vecs[i].p, vecs[i].l, vecs[i].c);
            chk($sformatf("vec%0d.hr", i), 32'(hr), vecs[i].eh);
            chk($sformatf("vec%0d.min", i), 32'(min), vecs[i].em);
            chk($sformatf("vec%0d.sec", i), 32'(sec), vecs[i].es);
            chk($sformatf("vec%0d.running", i), 32'(running), vecs[i].erun);
            chk($sformatf("vec%0d.lap_valid", i), 32'(lap_valid), vecs[i].elv);
            chk($sformatf("vec%0d.lap_cnt", i), 32'(lap_cnt), vecs[i].elc);
            chk($sformatf("vec%0d.lap_sec", i), 32'(lap_sec), vecs[i].elsec);
            chk($sformatf("vec%0d.overflow", i), 32'(overflow), 0);
        end

        // Start edge, then 65 increments -> 0:01:05
        do_reset();
        tick(1, 1, 0, 0, 0);
        chk("start_running", 32'(running), 1);
        chk("start_sec", 32'(sec), 0);
        for (int i = 0; i < 65; i++) tick(1, 0, 0, 0, 0);
        chk("t65_hr", 32'(hr), 0);
        chk("t65_min", 32'(min), 1);
        chk("t65_sec", 32'(sec), 5);

        // Stop and start together in RUN pauses; resume increments one cycle after start
        do_reset();
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick(1, 0, 0, 0, 0);
        chk("pre_pause_sec", 32'(sec), 20);
        tick(1, 1, 1, 0, 0);
        chk("pause_sec", 32'(sec), 20);
        chk("pause_running", 32'(running), 0);
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 0, 0);
            chk("pause_hold_sec", 32'(sec), 20);
        end
        tick(1, 1, 0, 0, 0);
        chk("resume_sec", 32'(sec), 20);
        chk("resume_running", 32'(running), 1);
        tick(1, 0, 0, 0, 0);
        chk("resume_next_sec", 32'(sec), 21);

        // Three laps, then lap and clear together at 0:00:30
        do_reset();
        tick(1, 1, 0, 0, 0);
        for (int i = 1; i <= 30; i++) tick(1, 0, 0, (i == 5 || i == 10 || i == 15), 0);
        chk("laps_sec", 32'(sec), 30);
        chk("laps_cnt", 32'(lap_cnt), 3);
        chk("laps_lap_sec", 32'(lap_sec), 14);
        tick(1, 0, 0, 1, 1);
        chk("lapclr_sec", 32'(sec), 0);
        chk("lapclr_running", 32'(running), 0);
        chk("lapclr_lap_valid", 32'(lap_valid), 0);
        chk("lapclr_lap_cnt", 32'(lap_cnt), 0);
        chk("lapclr_lap_sec", 32'(lap_sec), 0);

        // lap_cnt saturates at 15
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            tick(1, 0, 0, 1, 0);
            tick(1, 0, 0, 0, 0);
        end
        chk("lap_cnt_sat", 32'(lap_cnt), 15);

        // Run to the hour limit with the model checked every cycle
        do_reset();
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < LIMIT; i++) begin
            tick(1, 0, 0, 0, 0);
            cmp_model("ramp");
        end
        chk("limit_hr", 32'(hr), 1);
        chk("limit_min", 32'(min), 59);
        chk("limit_sec", 32'(sec), 59);
        tick(1, 0, 0, 0, 0);
`ifdef STOPWATCH_WRAP_EN
        chk("wrap_hr", 32'(hr), 0);
        chk("wrap_sec", 32'(sec), 0);
        chk("wrap_overflow", 32'(overflow), 1);
        chk("wrap_running", 32'(running), 1);
        tick(1, 0, 0, 0, 0);
        chk("wrap_after_overflow", 32'(overflow), 0);
        chk("wrap_after_sec", 32'(sec), 1);
`else
        chk("ovf_hr", 32'(hr), 1);
        chk("ovf_sec", 32'(sec), 59);
        chk("ovf_overflow", 32'(overflow), 1);
        chk("ovf_running", 32'(running), 0);
        tick(1, 1, 0, 0, 0);
        chk("ovf_start_running", 32'(running), 0);
        chk("ovf_start_min", 32'(min), 59);
        tick(1, 0, 0, 1, 0);
        chk("ovf_lap_cnt", 32'(lap_cnt), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        tick(1, 0, 0, 0, 1);
        chk("ovf_clear_overflow", 32'(overflow), 0);
        chk("ovf_clear_hr", 32'(hr), 0);
`endif

        // Start held through reset release needs release and re-press
        tick(0, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        chk("held_start_running", 32'(running), 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        chk("repress_running", 32'(running), 1);
        for (int i = 0; i < 120; i++) tick(1, 0, 0, 0, 0);
        chk("t120_min", 32'(min), 2);
        chk("t120_sec", 32'(sec), 0);
        tick(0, 0, 0, 1, 0);
        chk("rst_run_min", 32'(min), 0);
        chk("rst_run_running", 32'(running), 0);
        chk("rst_run_lap_valid", 32'(lap_valid), 0);
        chk("rst_run_lap_cnt", 32'(lap_cnt), 0);
        chk("rst_run_overflow", 32'(overflow), 0);

        // Randomized buttons against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 79) == 0));
            cmp_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch.md
# stopwatch

Count-up elapsed-time counter; the opposite direction of the countdown timer. It runs on the same 1 Hz clock and feeds the same hr/min/sec display path. Start, stop, lap and clear are button inputs with internal rising-edge detection. The block provides a lap capture register and overflow handling at a parameterised hour limit.

## Interface
- MAX_HR, default 23: highest hour value; the count tops out at MAX_HR:59:59 (legal range 1..31).
- clk_1hz  input  1  1 Hz clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  start/resume button, level, synchronous to clk_1hz.
- stop  input  1  pause button, level.
- lap  input  1  lap-capture button, level.
- clear  input  1  clear button, level.
- hr  output  5  running hours.
- min  output  6  running minutes.
- sec  output  6  running seconds.
- lap_hr  output  5  captured hours.
- lap_min  output  6  captured minutes.
- lap_sec  output  6  captured seconds.
- lap_valid  output  1  a lap has been captured since the last clear.
- lap_cnt  output  4  number of laps captured, saturating at 15.
- running  output  1  high exactly when the state is RUN.
- overflow  output  1  overflow indication (see Configuration).

## Operation
- Edge detection
  - Each button has a delay register; edge = input & ~delayed.
  - The delay registers reset to 1. A button held through reset fires only after release and re-press.
- States: IDLE, RUN, PAUSE, OVF.
- Priority within one cycle
  - clear edge beats all other inputs, in every state.
  - In RUN, stop beats start.
  - In IDLE and PAUSE, start beats stop.
- Transitions
  - IDLE
    - start edge -> RUN. The count stays 00:00:00 this cycle.
    - All other inputs are ignored.
  - RUN
    - Increments sec every cycle unless the cycle takes a stop or clear edge.
    - sec 59 -> 0 with min+1; min 59 -> 0 with hr+1.
    - stop edge -> PAUSE, with no increment that cycle.
    - lap edge: lap_* <= the pre-increment count, lap_valid <= 1, lap_cnt <= lap_cnt+1 (saturating at 15). Counting continues.
    - lap and stop edges in the same cycle: lap captures and the state goes to PAUSE.
    - Increment at MAX_HR:59:59: behaviour depends on the macro (see Configuration).
  - PAUSE
    - The count holds.
    - start edge -> RUN; counting resumes on the next cycle.
    - lap and stop are ignored.
  - OVF
    - The count holds at MAX_HR:59:59 and overflow = 1.
    - Only a clear edge exits.
  - clear edge, any state -> IDLE. In that cycle the count, lap_*, lap_valid and lap_cnt all become 0, and overflow becomes 0.
- Arithmetic
  - Counters are unsigned.
  - min and sec never exceed 59; hr never exceeds MAX_HR.

## Timing
- Reset (rst_n low at a rising edge)
  - State -> IDLE.
  - All outputs -> 0, including running and overflow.
  - Delay registers -> 1.
- rst_n low mid-run clears everything at that edge, with no lap capture.
- Button latency: a button first sampled high at edge k changes state at edge k.
- running
  - Rises at the edge where the start edge is taken.
  - The first increment (sec = 1) occurs at edge k+1.
- lap_* and lap_valid update at the same edge that detects the lap.
- A button held high produces exactly one edge.

## Configuration
- STOPWATCH_WRAP_EN defined
  - The increment at MAX_HR:59:59 wraps to 00:00:00 and the state stays RUN.
  - overflow is a 1-cycle pulse at the wrap edge.
  - OVF is unreachable.
- STOPWATCH_WRAP_EN undefined
  - The increment at MAX_HR:59:59 does not change the count.
  - State -> OVF: running = 0 and overflow = 1, both sticky until clear.

## Test plan
- Reset, start pulse at edge 1 -> running=1 at edge 1; at edge 66 hr:min:sec = 0:01:05.
- Run to 0:00:10, lap pulse -> lap = 0:00:10, lap_valid=1, lap_cnt=1; count continues to 0:00:11 at the same edge.
- Run to 0:00:20, stop and start high in the same cycle -> PAUSE at 0:00:20; count holds for 5 cycles; a later start resumes with 0:00:21 one cycle after the start edge.
- MAX_HR=1, run to 1:59:59 -> without the macro: holds 1:59:59, overflow=1, running=0, start ignored. With the macro: 0:00:00, overflow high 1 cycle, running stays 1.
- Lap and clear in the same cycle at 0:00:30 with lap_cnt=3 -> IDLE, all zero, lap_valid=0, lap_cnt=0.
- start held high through reset release -> no start until start goes low then high; rst_n low in RUN at 0:02:00 -> all outputs 0 at that edge.
